// File: rtl/uart_tx_arbiter_if.sv
// Request/acknowledge bundle between two byte requesters, the arbiter and the uart_tx serializer.
// No storage: pure wiring; latency and backpressure are defined by uart_tx_arbiter.
// The bus is held off by valid-until-ack on the request side and by tx_done on the serializer side.
interface uart_tx_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_byte;
    logic       ack0;
    logic       req1_valid;
    logic [7:0] req1_byte;
    logic       ack1;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_done;
    logic       busy;
    logic       grant_id;
    logic       err_clr;
    logic       timeout_err;

    modport slave (
        input  req0_valid, req0_byte, req1_valid, req1_byte, tx_done, err_clr,
        output ack0, ack1, tx_dv, tx_byte, busy, grant_id, timeout_err
    );

    modport master (
        output req0_valid, req0_byte, req1_valid, req1_byte, tx_done, err_clr,
        input  ack0, ack1, tx_dv, tx_byte, busy, grant_id, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between two byte ports, round-robin (fixed priority when UART_TX_ARB_FIXED_PRIO_EN is defined).
// Latency: valid at edge t -> tx_dv in cycle t+1; tx_done at edge d -> ack in cycle d+1; next grant at edge d+2.
// Backpressure: requester holds valid until its ack; a watchdog forces release if tx_done never arrives.
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16384,
    parameter int unsigned CNT_W          = 15
) (
    input  logic             i_Clk,
    input  logic             reset_,
    uart_tx_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             grant_q, grant_d;
    logic             err_q, err_d;
    logic             any_req;
    logic             win;

`ifndef UART_TX_ARB_FIXED_PRIO_EN
    logic             last_q, last_d;
`endif

    always_comb begin
        any_req = bus.req0_valid | bus.req1_valid;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        win = ~bus.req0_valid;
`else
        // On a tie the port that did not win last time goes next.
        win = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_byte_d = tx_byte_q;
        grant_d   = grant_q;
        err_d     = err_q;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
        last_d    = last_q;
`endif
        if (bus.err_clr) begin
            err_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant_d   = win;
                    tx_byte_d = win ? bus.req1_byte : bus.req0_byte;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A done arriving on the last count still counts as a clean finish.
                if (bus.tx_done) begin
                    state_d = S_RELEASE;
                end else if (cnt_d == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
`ifndef UART_TX_ARB_FIXED_PRIO_EN
                last_d  = grant_q;
`endif
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!reset_) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tx_byte_q <= 8'h00;
            grant_q   <= 1'b0;
            err_q     <= 1'b0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            last_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_byte_q <= tx_byte_d;
            grant_q   <= grant_d;
            err_q     <= err_d;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            last_q    <= last_d;
`endif
        end
    end

    assign bus.tx_dv       = (state_q == S_LAUNCH);
    assign bus.tx_byte     = tx_byte_q;
    assign bus.ack0        = (state_q == S_RELEASE) & ~grant_q;
    assign bus.ack1        = (state_q == S_RELEASE) &  grant_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.grant_id    = grant_q;
    assign bus.timeout_err = err_q;

`ifndef SYNTHESIS
    a_ack_onehot: assert property (@(posedge i_Clk) !(bus.ack0 && bus.ack1));
    a_dv_single:  assert property (@(posedge i_Clk) disable iff (!reset_) bus.tx_dv |=> !bus.tx_dv);
`endif

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single uart_tx serializer between two byte requesters.
- Port 0 is the LC-3 console path: the OUTPUT handshake block, with the DDR byte. Port 1 is a debug/monitor byte stream.
- Arbitrates round-robin, launches one byte at a time on uart_tx, waits for its done pulse, then acknowledges the winner.
- A watchdog recovers if the done pulse never arrives.

Parameters:
- TIMEOUT_CYCLES, default 16384: maximum cycles in WAIT before a forced release. Must be at least 2, and larger than one frame time at CLKS_PER_BIT.
- CNT_W, default 15: timeout counter width. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- i_Clk  in  1  system clock; all logic on the rising edge.
- reset_  in  1  synchronous, active-low reset.
- req0_valid  in  1  port 0 has a byte; held high until ack0.
- req0_byte  in  8  port 0 data; stable while req0_valid is high.
- ack0  out  1  one-cycle pulse: port 0 byte fully transmitted (or timed out).
- req1_valid  in  1  port 1 has a byte.
- req1_byte  in  8  port 1 data.
- ack1  out  1  one-cycle pulse for port 1.
- tx_dv  out  1  to uart_tx i_Tx_DV; one-cycle start pulse.
- tx_byte  out  8  to uart_tx i_Tx_Byte; registered.
- tx_done  in  1  from uart_tx o_Tx_Done.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  1  port currently (or last) granted.
- err_clr  in  1  clears timeout_err.
- timeout_err  out  1  sticky flag: a transfer ended by watchdog.

Behaviour:
- Reset values (reset_ low at an edge): state IDLE, tx_dv 0, tx_byte 0x00, ack0 0, ack1 0, busy 0, grant_id 0, timeout_err 0, counter 0, last_grant 1 (so port 0 wins the first tie).
- States: IDLE -> LAUNCH -> WAIT -> RELEASE -> IDLE.
- IDLE:
  - Only one valid: grant that port.
  - Both valid: grant the port that is not last_grant.
  - On grant: latch the winner's byte into tx_byte, set grant_id, go to LAUNCH.
  - Neither valid: stay in IDLE.
- LAUNCH: tx_dv = 1 for exactly this one cycle; counter cleared; next state WAIT.
- WAIT:
  - Counter increments each cycle.
  - tx_done = 1: go to RELEASE.
  - Counter reaches TIMEOUT_CYCLES-1 without tx_done: set timeout_err, go to RELEASE.
  - If tx_done and the timeout occur in the same cycle, tx_done wins; timeout_err is not set.
- RELEASE: pulse ack[grant_id] for 1 cycle; last_grant <= grant_id; next state IDLE.
- Latency:
  - valid seen in IDLE at edge t gives tx_dv high during cycle t+1.
  - tx_done seen at edge d gives ack during cycle d+1.
  - Next grant is possible at edge d+2.
  - Back-to-back throughput is one byte per frame time plus 3 cycles.
- tx_done is sampled only in WAIT. In IDLE, LAUNCH or RELEASE it is ignored (covers a stale done after reset).
- tx_byte holds its value from LAUNCH until the next grant. Changes on reqN_byte after the grant have no effect.
- Requester drops valid after the grant: the transfer still completes and ack is still pulsed. The requester must tolerate an ack it no longer waits for.
- Requester holds valid through ack: it is re-arbitrated in IDLE as a new byte. It must drop valid in the cycle after ack if it has no new byte.
- err_clr = 1 clears timeout_err. A set in the same cycle wins over the clear.
- reset_ low mid-transfer: returns to reset values at that edge; no ack is issued. uart_tx may still finish the frame; its done is ignored.
- ack0 and ack1 are never high together. busy = (state != IDLE).

Optional Feature:
- Macro: UART_TX_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Port 0 always wins when both ports are valid; last_grant is unused and port 1 may starve.
- Undefined (default): round-robin as described in Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Single port 0 request:
  - Stimulus: req0_valid with byte 0x41; bench tx model asserts tx_done 20 cycles after tx_dv.
  - Required: tx_dv exactly 1 cycle wide with tx_byte = 0x41; ack0 exactly 1 cycle wide, 1 cycle after tx_done; ack1 never; busy falls with the return to IDLE.
- Simultaneous requests, held:
  - Stimulus: bytes 0x10 and 0x20 presented together, each port holding three bytes.
  - Required (round-robin): output order 0x10,0x20,0x10,0x20,... alternating ports.
  - Required (macro defined): all port 0 bytes first.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8; tx_done never asserted.
  - Required: ack0 pulses 8 cycles after LAUNCH; timeout_err = 1 and stays set; err_clr pulse returns it to 0.
- Done and timeout in the same cycle:
  - Stimulus: tx_done arrives on the final count.
  - Required: ack pulses; timeout_err remains 0.
- Reset during WAIT:
  - Stimulus: reset_ low for 1 cycle during WAIT; then stale tx_done 3 cycles later.
  - Required: no ack; busy = 0; stale done ignored; state stays IDLE.
- Stale tx_done:
  - Stimulus: tx_done while IDLE and in LAUNCH; also a byte change after grant (0x55 -> 0xAA).
  - Required: stale done ignored; tx_byte stays 0x55.
